// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Control FSM for a multi-cycle MIPS datapath. It sequences the shared ALU,
// the unified instruction/data memory and the register file over 3-5 cycles
// per instruction (R-type, j, beq, addiu, lw, sw). Memory states wait on a
// ready handshake, and a watchdog aborts an access that never completes.
//
// Ports:
//   clock_in         system clock, rising edge
//   reset_in         synchronous reset, active-high (forces all outputs to 0)
//   opcode_in[5:0]   opcode from the instruction register
//   memReady_in      memory completed the current access this cycle
//   pcWrite_out      unconditional PC write
//   pcWriteCond_out  PC write gated by ALU zero
//   pcSource_out     PC mux: 00 ALU, 01 ALUOut, 10 jump target
//   iorD_out         memory address mux: 0 PC, 1 ALUOut
//   memRead_out      memory read request
//   memWrite_out     memory write request
//   irWrite_out      load instruction register
//   memtoReg_out     write-back data mux: 1 memory data register
//   regDst_out       destination register mux: 1 rd, 0 rt
//   regWrite_out     register file write enable
//   aluSrcA_out      ALU A mux: 0 PC, 1 register A
//   aluSrcB_out      ALU B mux: 00 B, 01 4, 10 sign-ext imm, 11 shifted imm
//   aluOp_out        00 add, 01 subtract, 10 funct field
//   state_out[3:0]   current state encoding (debug)
//   instrDone_out    pulse in the final cycle of a completed instruction
//   illegal_out      pulse one cycle after decoding an unsupported opcode
//   memError_out     pulse one cycle after a memory wait timeout
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clock_in,
    input  logic       reset_in,
    input  logic [5:0] opcode_in,
    input  logic       memReady_in,
    output logic       pcWrite_out,
    output logic       pcWriteCond_out,
    output logic [1:0] pcSource_out,
    output logic       iorD_out,
    output logic       memRead_out,
    output logic       memWrite_out,
    output logic       irWrite_out,
    output logic       memtoReg_out,
    output logic       regDst_out,
    output logic       regWrite_out,
    output logic       aluSrcA_out,
    output logic [1:0] aluSrcB_out,
    output logic [1:0] aluOp_out,
    output logic [3:0] state_out,
    output logic       instrDone_out,
    output logic       illegal_out,
    output logic       memError_out
);

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADDR  = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_REXEC    = 4'd6,
        ST_RWB      = 4'd7,
        ST_BRANCH   = 4'd8,
        ST_JUMP     = 4'd9,
        ST_ADDIEXEC = 4'd10,
        ST_ADDIWB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Last counter value before the watchdog fires.
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_wait_cnt;
    logic       r_illegal;
    logic       r_mem_error;
    logic       w_wait_state;
    logic       w_timeout;
    logic       w_illegal;

    // States that stall on the memory handshake.
    assign w_wait_state = (r_state == ST_FETCH) || (r_state == ST_MEMREAD) ||
                          (r_state == ST_MEMWRITE);

    // Ready in the final wait cycle wins over the timeout.
    assign w_timeout = w_wait_state && !memReady_in && (r_wait_cnt == TIMEOUT_LAST);

    // Next-state logic.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_next_state = r_state;
        w_illegal    = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (memReady_in) w_next_state = ST_DECODE;
                else             w_next_state = ST_FETCH;
            end
            ST_DECODE: begin
                case (opcode_in)
                    OP_LW, OP_SW: w_next_state = ST_MEMADDR;
                    OP_RTYPE:     w_next_state = ST_REXEC;
                    OP_BEQ:       w_next_state = ST_BRANCH;
                    OP_J:         w_next_state = ST_JUMP;
                    OP_ADDIU:     w_next_state = ST_ADDIEXEC;
                    default: begin
                        w_next_state = ST_FETCH;
                        w_illegal    = 1'b1;
                    end
                endcase
            end
            ST_MEMADDR:  w_next_state = (opcode_in == OP_LW) ? ST_MEMREAD : ST_MEMWRITE;
            ST_MEMREAD: begin
                if (memReady_in)    w_next_state = ST_MEMWB;
                else if (w_timeout) w_next_state = ST_FETCH;
                else                w_next_state = ST_MEMREAD;
            end
            ST_MEMWRITE: begin
                if (memReady_in)    w_next_state = ST_FETCH;
                else if (w_timeout) w_next_state = ST_FETCH;
                else                w_next_state = ST_MEMWRITE;
            end
            ST_REXEC:    w_next_state = ST_RWB;
            ST_ADDIEXEC: w_next_state = ST_ADDIWB;
            ST_MEMWB, ST_RWB, ST_BRANCH, ST_JUMP, ST_ADDIWB:
                         w_next_state = ST_FETCH;
            default:     w_next_state = ST_FETCH;  // unreachable encodings recover
        endcase
    end

    // State register, wait counter and the delayed status pulses.
    always_ff @(posedge clock_in) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset_in) begin
            r_state     <= ST_FETCH;
            r_wait_cnt  <= 8'd0;
            r_illegal   <= 1'b0;
            r_mem_error <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_illegal   <= w_illegal;
            r_mem_error <= w_timeout;
            // A timeout in FETCH keeps the state, so it clears explicitly.
            if (w_timeout || (w_next_state != r_state))
                r_wait_cnt <= 8'd0;
            else if (w_wait_state && !memReady_in)
                r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    // Control outputs, decoded from the state; all forced low during reset.
    always_comb begin
        pcWrite_out     = 1'b0;
        pcWriteCond_out = 1'b0;
        pcSource_out    = 2'b00;
        iorD_out        = 1'b0;
        memRead_out     = 1'b0;
        memWrite_out    = 1'b0;
        irWrite_out     = 1'b0;
        memtoReg_out    = 1'b0;
        regDst_out      = 1'b0;
        regWrite_out    = 1'b0;
        aluSrcA_out     = 1'b0;
        aluSrcB_out     = 2'b00;
        aluOp_out       = 2'b00;
        instrDone_out   = 1'b0;
        state_out       = r_state;
        illegal_out     = r_illegal;
        memError_out    = r_mem_error;
        case (r_state)
            ST_FETCH: begin
                memRead_out = 1'b1;
                aluSrcB_out = 2'b01;
                irWrite_out = memReady_in;
                pcWrite_out = memReady_in;
            end
            ST_DECODE: aluSrcB_out = 2'b11;
            ST_MEMADDR: begin
                aluSrcA_out = 1'b1;
                aluSrcB_out = 2'b10;
            end
            ST_MEMREAD: begin
                memRead_out = 1'b1;
                iorD_out    = 1'b1;
            end
            ST_MEMWB: begin
                memtoReg_out  = 1'b1;
                regWrite_out  = 1'b1;
                instrDone_out = 1'b1;
            end
            ST_MEMWRITE: begin
                memWrite_out  = 1'b1;
                iorD_out      = 1'b1;
                instrDone_out = memReady_in;
            end
            ST_REXEC: begin
                aluSrcA_out = 1'b1;
                aluOp_out   = 2'b10;
            end
            ST_RWB: begin
                regDst_out    = 1'b1;
                regWrite_out  = 1'b1;
                instrDone_out = 1'b1;
            end
            ST_BRANCH: begin
                aluSrcA_out     = 1'b1;
                aluOp_out       = 2'b01;
                pcWriteCond_out = 1'b1;
                pcSource_out    = 2'b01;
                instrDone_out   = 1'b1;
            end
            ST_JUMP: begin
                pcWrite_out   = 1'b1;
                pcSource_out  = 2'b10;
                instrDone_out = 1'b1;
            end
            ST_ADDIEXEC: begin
                aluSrcA_out = 1'b1;
                aluSrcB_out = 2'b10;
            end
            ST_ADDIWB: begin
                regWrite_out  = 1'b1;
                instrDone_out = 1'b1;
            end
            default: ;
        endcase
        if (reset_in) begin
            pcWrite_out     = 1'b0;
            pcWriteCond_out = 1'b0;
            pcSource_out    = 2'b00;
            iorD_out        = 1'b0;
            memRead_out     = 1'b0;
            memWrite_out    = 1'b0;
            irWrite_out     = 1'b0;
            memtoReg_out    = 1'b0;
            regDst_out      = 1'b0;
            regWrite_out    = 1'b0;
            aluSrcA_out     = 1'b0;
            aluSrcB_out     = 2'b00;
            aluOp_out       = 2'b00;
            instrDone_out   = 1'b0;
            state_out       = 4'd0;
            illegal_out     = 1'b0;
            memError_out    = 1'b0;
        end
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle MIPS control unit: an FSM that sequences one shared ALU, a unified instruction/data memory and the register file over 3–5 cycles per instruction.
- Supports the same opcode set as the single-cycle decoder: R-type, j, beq, addiu, lw, sw.
- Sits between the instruction register (which supplies `opcode_in`) and the multi-cycle datapath muxes and write enables.
- Adds memory wait-state handshaking with a timeout watchdog.

Parameters:
- MEM_TIMEOUT, 15: maximum cycles spent waiting on `memReady_in` in a memory state before abort. Legal range 1..255.

Ports:
- clock_in  input  1  system clock, rising edge
- reset_in  input  1  synchronous reset, active-high
- opcode_in  input  6  opcode field from the instruction register; stable from DECODE until the instruction completes
- memReady_in  input  1  memory has completed the current access this cycle
- pcWrite_out  output  1  unconditional PC write
- pcWriteCond_out  output  1  PC write gated by ALU zero (beq)
- pcSource_out  output  2  PC mux: 00 ALU result, 01 ALUOut register, 10 jump target
- iorD_out  output  1  memory address mux: 0 PC, 1 ALUOut
- memRead_out  output  1  memory read request
- memWrite_out  output  1  memory write request
- irWrite_out  output  1  load instruction register
- memtoReg_out  output  1  write-back data mux: 1 memory data register
- regDst_out  output  1  destination register mux: 1 rd, 0 rt
- regWrite_out  output  1  register file write enable
- aluSrcA_out  output  1  ALU A mux: 0 PC, 1 register A
- aluSrcB_out  output  2  ALU B mux: 00 register B, 01 constant 4, 10 sign-extended immediate, 11 shifted immediate
- aluOp_out  output  2  00 add, 01 subtract, 10 use funct field
- state_out  output  4  current state encoding, for debug
- instrDone_out  output  1  one-cycle pulse in the final cycle of each completed instruction
- illegal_out  output  1  one-cycle pulse on an unsupported opcode
- memError_out  output  1  one-cycle pulse on memory timeout

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is synchronous and active-high on `reset_in`.
  - Reset sets state to FETCH, clears the wait counter and clears all flag registers.
- Output rules:
  - Control outputs are decoded combinationally from the state (plus `memReady_in` where noted).
  - Every output not listed for a state is 0.
  - While `reset_in` = 1, all outputs are forced to 0, including `state_out`.
- State encodings and per-state actions:
  - FETCH (0): memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00. irWrite=pcWrite=`memReady_in`. On ready go to DECODE; otherwise hold.
  - DECODE (1): aluSrcA=0, aluSrcB=11, aluOp=00 (branch target into ALUOut). Next state by opcode:
    - 100011 or 101011 → MEMADDR
    - 000000 → REXEC
    - 000100 → BRANCH
    - 000010 → JUMP
    - 001001 → ADDIEXEC
    - any other opcode → FETCH, with `illegal_out` pulsing in the following cycle.
  - MEMADDR (2): aluSrcA=1, aluSrcB=10, aluOp=00. Go to MEMREAD if opcode is 100011, else MEMWRITE.
  - MEMREAD (3): memRead=1, iorD=1. On ready go to MEMWB; otherwise hold.
  - MEMWB (4): regDst=0, memtoReg=1, regWrite=1, instrDone=1. Go to FETCH.
  - MEMWRITE (5): memWrite=1, iorD=1, instrDone=`memReady_in`. On ready go to FETCH.
  - REXEC (6): aluSrcA=1, aluSrcB=00, aluOp=10. Go to RWB.
  - RWB (7): regDst=1, regWrite=1, instrDone=1. Go to FETCH.
  - BRANCH (8): aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=01, instrDone=1. Go to FETCH.
  - JUMP (9): pcWrite=1, pcSource=10, instrDone=1. Go to FETCH.
  - ADDIEXEC (10): aluSrcA=1, aluSrcB=10, aluOp=00. Go to ADDIWB.
  - ADDIWB (11): regDst=0, memtoReg=0, regWrite=1, instrDone=1. Go to FETCH.
  - Encodings 12–15 are unreachable. If ever entered, the next state is FETCH.
- Wait counter (8 bits):
  - Cleared on every state change.
  - Increments each cycle spent in FETCH, MEMREAD or MEMWRITE with `memReady_in` = 0.
  - When the counter equals MEM_TIMEOUT-1 and `memReady_in` = 0:
    - next state is FETCH and the counter clears;
    - `memError_out` pulses in the next cycle;
    - no irWrite, pcWrite or regWrite is issued for the aborted access.
  - If `memReady_in` = 1 in that same cycle, ready wins and no error is raised.
  - A timeout in FETCH re-fetches from the unchanged PC.
- Latency with zero wait states (cycles from FETCH entry to instrDone):
  - lw 5, sw 4, R-type 4, addiu 4, beq 3, j 3.
- Reset asserted mid-instruction: abort immediately, state returns to FETCH on the next clock, no pending write completes.

Test Plan:
- Reset held 2 cycles, then released; `opcode_in`=000000, `memReady_in`=1 → state sequence 0,1,6,7,0; regDst=1 and regWrite=1 in state 7; instrDone pulses once.
- lw (100011), `memReady_in`=1 except 3 low cycles in MEMREAD → states 0,1,2,3,3,3,3,4,0; memRead=1 and iorD=1 throughout state 3; memtoReg=1 and regWrite=1 in state 4.
- sw (101011), then beq (000100), then j (000010), ready always 1 → sw: memWrite=1 only in state 5; beq: pcWriteCond=1 with pcSource=01 and aluOp=01; j: pcWrite=1 with pcSource=10; latencies 4, 3, 3 cycles.
- Opcode 111111 → state sequence 0,1,0; `illegal_out`=1 for exactly one cycle; regWrite, memWrite and pcWrite never asserted after FETCH.
- MEM_TIMEOUT=4, `memReady_in` held 0 in MEMREAD → 4 cycles in state 3, then FETCH; `memError_out` pulses once; no regWrite.
- Edge and abort cases:
  - With MEM_TIMEOUT=4, ready rises exactly on the 4th wait cycle → no error and the instruction completes.
  - `reset_in` asserted in state 4 → regWrite=0 that cycle; state 0 after release.
